aes_tag_finalize: RTL

AES_TAG_FINALIZE -- requirements
Module: aes_tag_finalize

---
 rtl/aes_tag_finalize.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/aes_tag_finalize.sv
// GCM tag finalisation: tag = ((S ^ len) * H) ^ E(K,J0), truncated to TAG_LEN bits.
// Latency: tag valid 128/BITS_PER_CYCLE cycles after the capture edge.
// Backpressure: tag held in DONE until i_tag_ready; i_valid while busy is dropped and flagged.
module aes_tag_finalize #(
    parameter int BITS_PER_CYCLE = 8,
    parameter int TAG_LEN        = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [0:127] i_sblock,
    input  logic [0:127] i_len_block,
    input  logic [0:127] i_h,
    input  logic [0:127] i_encrypted_j0,
    input  logic         i_tag_ready,
    output logic         o_busy,
    output logic         o_tag_valid,
    output logic [0:127] o_tag,
    output logic         o_overrun
);
    localparam int           NUM_CYCLES = 128 / BITS_PER_CYCLE;
    localparam logic [7:0]   LAST_CNT   = 8'(NUM_CYCLES - 1);
    // Bit 0 is the MSB (GCM bit order), so 0xE1 lands in bits 0..7.
    localparam logic [0:127] R_POLY     = 128'hE1 << 120;
    localparam logic [0:127] ONES       = '1;
    // Keeps bits 0..TAG_LEN-1, zeroes the truncated tail.
    localparam logic [0:127] TAG_MASK   = ~(ONES >> TAG_LEN);

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic         capture;
    logic         finish;
    logic         release_tag;
    logic [0:127] x;
    logic [0:127] v;
    logic [0:127] z;
    logic [0:127] j;
    logic [7:0]   cnt;
    logic [0:127] z_step;
    logic [0:127] v_step;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the one-cycle event strobes that drive the datapath.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        finish      = 1'b0;
        release_tag = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_nxt = MULT;
                    capture   = 1'b1;
                end
            end
            MULT: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                if (i_tag_ready) begin
                    state_nxt   = IDLE;
                    release_tag = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    // BITS_PER_CYCLE shift-and-add steps of the GF(2^128) multiply; x is pre-shifted so
    // the bits for this cycle are always x[0 .. BITS_PER_CYCLE-1].
    always_comb begin
        z_step = z;
        v_step = v;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (x[i]) begin
                z_step = z_step ^ v_step;
            end
            if (v_step[127]) begin
                v_step = (v_step >> 1) ^ R_POLY;
            end else begin
                v_step = v_step >> 1;
            end
        end
    end

    // Multiplier operands: loaded on capture, advanced every MULT cycle, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            v   <= '0;
            z   <= '0;
            j   <= '0;
            cnt <= '0;
        end else if (capture) begin
            x   <= i_sblock ^ i_len_block;
            v   <= i_h;
            z   <= '0;
            j   <= i_encrypted_j0;
            cnt <= '0;
        end else if (state == MULT) begin
            x   <= x << BITS_PER_CYCLE;
            v   <= v_step;
            z   <= z_step;
            cnt <= cnt + 8'd1;
        end
    end

    // Output tag register, its valid flag, and the sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_tag       <= '0;
            o_tag_valid <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (finish) begin
                o_tag       <= (z_step ^ j) & TAG_MASK;
                o_tag_valid <= 1'b1;
            end else if (release_tag) begin
                o_tag_valid <= 1'b0;
            end
            if (i_valid && (state != IDLE)) begin
                o_overrun <= 1'b1;
            end
        end
    end

endmodule
